// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions used by the instruction fetch stage: reset vector,
// NOP encoding, fetch FSM state encoding and an alignment helper.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INST             = 32'h0000_0000;
    localparam logic [31:0] PC_STEP              = 32'd4;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_pc_next_sel.sv
// Priority mux for the next fetch address: boot vector, flush redirect,
// branch redirect, sequential advance, or hold.
module inst_fetch_pc_next_sel
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        boot,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] pc_f,
    output logic [31:0] next_pc
);

    // Flush outranks a branch; a branch only counts when the pipe advances.
    always_comb begin
        next_pc = pc_f;
        if (boot) begin
            next_pc = RESET_VECTOR;
        end else if (flush) begin
            next_pc = flush_pc;
        end else if (stall && branch_taken) begin
            next_pc = branch_target;
        end else if (stall) begin
            next_pc = pc_f + PC_STEP;
        end else begin
            next_pc = pc_f;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// MIPS instruction fetch stage: owns the PC, drives the synchronous
// instruction SRAM and presents the fetched word to the IF/ID latch.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_is_branch,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] PC_out,
    output logic        illegal_pc_out,
    output logic        in_delayslot_out
);

    fetch_state_e state_r;
    logic [31:0]  pc_f_r;
    logic         valid_f_r;
    logic         ds_f_r;
    logic [31:0]  next_pc_s;
    logic         boot_s;
    logic         illegal_s;

    assign boot_s = (state_r == ST_BOOT);

    inst_fetch_pc_next_sel #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_next_sel (
        .boot          (boot_s),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_f          (pc_f_r),
        .next_pc       (next_pc_s)
    );

    // Fetch FSM plus the PC / valid / delay-slot registers of the IF stage.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state_r   <= ST_BOOT;
            pc_f_r    <= RESET_VECTOR - PC_STEP;
            valid_f_r <= 1'b0;
            ds_f_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: state_r <= ST_RUN;
                ST_RUN:  state_r <= ST_RUN;
                default: state_r <= ST_BOOT;
            endcase
            pc_f_r    <= next_pc_s;
            valid_f_r <= 1'b1;
            if (flush) begin
                ds_f_r <= 1'b0;
            end else if (stall) begin
                ds_f_r <= id_is_branch;
            end else begin
                ds_f_r <= ds_f_r;
            end
        end
    end

    // A misaligned target is never read; its flag travels on for AdEL.
    assign inst_sram_en     = rset & is_word_aligned(next_pc_s[1:0]);
    assign inst_sram_wen    = 4'b0000;
    assign inst_sram_addr   = {next_pc_s[31:2], 2'b00};
    assign inst_sram_wdata  = 32'h0000_0000;

    assign illegal_s        = valid_f_r & ~is_word_aligned(pc_f_r[1:0]);
    assign illegal_pc_out   = illegal_s;
    assign PC_out           = pc_f_r;
    assign instruction_out  = (valid_f_r & ~illegal_s) ? inst_sram_rdata : NOP_INST;
    assign in_delayslot_out = valid_f_r & ds_f_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a synchronous SRAM model whose
// contents are a fixed function of the word address.
module tb_inst_fetch;

    logic        clk;
    logic        rset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_is_branch;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] instruction_out;
    logic [31:0] PC_out;
    logic        illegal_pc_out;
    logic        in_delayslot_out;

    int total_cnt;
    int bad_cnt;

    inst_fetch dut (
        .clk              (clk),
        .rset             (rset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .id_is_branch     (id_is_branch),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .inst_sram_en     (inst_sram_en),
        .inst_sram_wen    (inst_sram_wen),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_rdata  (inst_sram_rdata),
        .instruction_out  (instruction_out),
        .PC_out           (PC_out),
        .illegal_pc_out   (illegal_pc_out),
        .in_delayslot_out (in_delayslot_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sram_word(input logic [31:0] addr);
        return addr ^ 32'hA5A5_5A5A;
    endfunction

    // Synchronous SRAM: data for the address presented appears next cycle.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= sram_word(inst_sram_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] pc);
        check({tag, ".pc"},   PC_out, pc);
        check({tag, ".inst"}, instruction_out, sram_word(pc));
        check({tag, ".ill"},  {31'd0, illegal_pc_out}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pc"},   PC_out, 32'hBFBF_FFFC);
        check({tag, ".inst"}, instruction_out, 32'h0000_0000);
        check({tag, ".ill"},  {31'd0, illegal_pc_out}, 32'd0);
        check({tag, ".ds"},   {31'd0, in_delayslot_out}, 32'd0);
        check({tag, ".en"},   {31'd0, inst_sram_en}, 32'd0);
    endtask

    initial begin
        total_cnt       = 0;
        bad_cnt         = 0;
        inst_sram_rdata = 32'h0000_0000;
        rset            = 1'b0;
        stall           = 1'b1;
        branch_taken    = 1'b0;
        branch_target   = 32'h0000_0000;
        id_is_branch    = 1'b0;
        flush           = 1'b0;
        flush_pc        = 32'h0000_0000;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        check("rst.wen",   {28'd0, inst_sram_wen}, 32'd0);
        check("rst.wdata", inst_sram_wdata, 32'd0);

        // Boot cycle issues the reset vector
        @(negedge clk);
        rset = 1'b1;
        #1;
        check("boot.pc",   PC_out, 32'hBFBF_FFFC);
        check("boot.inst", instruction_out, 32'h0000_0000);
        check("boot.en",   {31'd0, inst_sram_en}, 32'd1);
        check("boot.addr", inst_sram_addr, 32'hBFC0_0000);

        tick(); check_fetch("seq0", 32'hBFC0_0000);
        tick(); check_fetch("seq1", 32'hBFC0_0004);
        tick(); check_fetch("seq2", 32'hBFC0_0008);

        // Hold for three cycles
        stall = 1'b0;
        #1;
        check("hold.addr0", inst_sram_addr, 32'hBFC0_0008);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_fetch("hold", 32'hBFC0_0008);
            check("hold.addr", inst_sram_addr, 32'hBFC0_0008);
        end
        stall = 1'b1;
        tick(); check_fetch("resume", 32'hBFC0_000C);

        // Delay slot flag, then branch redirect
        id_is_branch = 1'b1;
        tick(); check_fetch("ds", 32'hBFC0_0010);
        check("ds.flag", {31'd0, in_delayslot_out}, 32'd1);
        id_is_branch  = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'hBFC0_0100;
        #1;
        check("br.addr", inst_sram_addr, 32'hBFC0_0100);
        tick(); check_fetch("br", 32'hBFC0_0100);
        check("br.ds", {31'd0, in_delayslot_out}, 32'd0);

        // Flush while held, with a competing branch
        stall         = 1'b0;
        branch_target = 32'hBFC0_0200;
        id_is_branch  = 1'b1;
        flush         = 1'b1;
        flush_pc      = 32'hBFC0_0380;
        tick(); check_fetch("flush", 32'hBFC0_0380);
        check("flush.ds", {31'd0, in_delayslot_out}, 32'd0);
        flush        = 1'b0;
        id_is_branch = 1'b0;

        // Branch while held is ignored
        branch_target = 32'hBFC0_0500;
        tick(); check_fetch("brhold", 32'hBFC0_0380);

        // Misaligned target
        stall         = 1'b1;
        branch_target = 32'hBFC0_0102;
        #1;
        check("mis.en0",   {31'd0, inst_sram_en}, 32'd0);
        check("mis.addr0", inst_sram_addr, 32'hBFC0_0100);
        tick();
        branch_taken = 1'b0;
        #1;
        check("mis.pc",   PC_out, 32'hBFC0_0102);
        check("mis.ill",  {31'd0, illegal_pc_out}, 32'd1);
        check("mis.inst", instruction_out, 32'h0000_0000);
        check("mis.en1",  {31'd0, inst_sram_en}, 32'd0);
        tick();
        check("mis2.pc",  PC_out, 32'hBFC0_0106);
        check("mis2.ill", {31'd0, illegal_pc_out}, 32'd1);

        // Address wrap
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        tick(); check_fetch("wrapa", 32'hFFFF_FFFC);
        flush = 1'b0;
        tick(); check_fetch("wrapb", 32'h0000_0000);

        // Asynchronous reset mid-run
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0040;
        tick(); check_fetch("pre_rst", 32'hBFC0_0040);
        flush = 1'b0;
        #2;
        rset = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        rset = 1'b1;
        tick(); check_fetch("restart0", 32'hBFC0_0000);
        tick(); check_fetch("restart1", 32'hBFC0_0004);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the MIPS pipeline. Owns the PC, drives the synchronous instruction SRAM, and produces the instruction, PC, misaligned-PC flag and delay-slot flag consumed by the IF/ID pipeline latch. Handles reset vector start-up, pipeline hold, taken branches/jumps from ID and exception/ERET redirects from the commit stage.

## Interface
Parameters:
- RESET_VECTOR, 32'hBFC00000, address of first fetched instruction

Ports:
- clk  in  1  rising-edge clock
- rset  in  1  asynchronous, active-low reset
- stall  in  1  pipeline advance enable; 1 = IF/ID captures this cycle, 0 = hold. Same polarity as the IF/ID latch enable.
- branch_taken  in  1  ID resolves a taken branch/jump this cycle
- branch_target  in  32  redirect target for branch_taken
- id_is_branch  in  1  ID holds a branch/jump, so the current IF instruction is its delay slot
- flush  in  1  exception/ERET redirect from commit stage; overrides everything
- flush_pc  in  32  redirect target for flush
- inst_sram_en  out  1  read enable
- inst_sram_wen  out  4  tied 4'b0000
- inst_sram_addr  out  32  read address
- inst_sram_wdata  out  32  tied 0
- inst_sram_rdata  in  32  read data, valid one cycle after address
- instruction_out  out  32  fetched instruction; 0 (nop) when bubble or misaligned
- PC_out  out  32  address of instruction_out
- illegal_pc_out  out  1  PC_out[1:0] != 0
- in_delayslot_out  out  1  instruction_out is a delay-slot instruction

## Operation
- Registers: pc_f (address whose data is on rdata this cycle), valid_f (pc_f holds a real fetch), ds_f (delay-slot flag).
- States: BOOT (after reset, no fetch issued) -> RUN. BOOT lasts exactly one cycle. RUN persists until reset.
- next_pc priority: flush -> flush_pc. Else stall=1 and branch_taken -> branch_target. Else stall=1 -> pc_f+4. Else (hold) -> pc_f.
- In BOOT, next_pc = RESET_VECTOR.
- inst_sram_addr = {next_pc[31:2],2'b00}.
- inst_sram_en = 1 when rset high and next_pc[1:0]==0; otherwise 0.
- Hold re-reads the same address, so rdata stays stable.
- Register update per clock:
  - pc_f <= next_pc.
  - valid_f <= 1, except it clears the cycle after reset.
  - ds_f <= id_is_branch when stall=1 and no flush; ds_f <= 0 on flush; ds_f unchanged on hold.
- Outputs (combinational from registers and rdata):
  - PC_out = pc_f.
  - illegal_pc_out = valid_f & (pc_f[1:0]!=0).
  - instruction_out = (valid_f & ~illegal_pc_out) ? inst_sram_rdata : 0.
  - in_delayslot_out = valid_f & ds_f.
- Address arithmetic: pc_f+4 is 32-bit modular. 32'hFFFFFFFC wraps to 0 with no flag.
- Misaligned target (jr to odd address): the fetch is suppressed, and the flag and PC propagate so ID/EX raises AdEL. Sequencing continues at pc_f+4.
- Delay slot: when branch_taken is seen with stall=1, the instruction currently in IF is the delay slot and is passed on. The target is fetched next, so no slot is squashed.

## Timing
- Reset (rset low, any time, asynchronous):
  - pc_f=RESET_VECTOR-4, valid_f=0, ds_f=0, state=BOOT.
  - Outputs: instruction_out=0, PC_out=RESET_VECTOR-4, illegal_pc_out=0, in_delayslot_out=0, inst_sram_en=0.
- First edge after rset rises: RESET_VECTOR is issued during the BOOT cycle. Its instruction appears on instruction_out one cycle later.
- Fetch latency: address issued at cycle N, instruction_out valid at cycle N+1.
- Throughput: one instruction per cycle while stall=1.
- Redirect: branch_taken or flush at cycle N -> PC_out = target at N+1.
- Flush during hold: flush wins; redirect happens even with stall=0.
- branch_taken with stall=0 is ignored. ID must hold it until it advances.
- Simultaneous flush and branch_taken: flush wins and the branch is dropped.

## Structure
- Shared cpu package holds RESET_VECTOR default (32'hBFC00000), the 32-bit NOP constant, and the BOOT/RUN state encoding.
- One natural sub-module: pc_next_sel, the combinational priority mux for next_pc. All other logic stays inline.

## Test plan
- Reset release, stall=1 held -> PC_out sequence BFBFFFFC, BFC00000, BFC00004, BFC00008. instruction_out = 0 until BFC00000, then the SRAM word at each address.
- stall=0 for 3 cycles at PC BFC00008 -> PC_out, instruction_out and inst_sram_addr stay constant. Advance resumes at BFC0000C.
- id_is_branch=1 and branch_taken=1 to BFC00100 at PC BFC00010 -> BFC00010 output with in_delayslot_out=1, then PC_out=BFC00100.
- flush=1 with flush_pc=BFC00380 while stall=0 and branch_taken=1 -> next PC_out=BFC00380, in_delayslot_out=0.
- branch_target=BFC00102 -> PC_out=BFC00102, illegal_pc_out=1, instruction_out=0, inst_sram_en=0 that cycle. Next PC_out=BFC00106.
- rset asserted mid-run at PC BFC00040 -> outputs return to reset values immediately (asynchronous). Restart fetches BFC00000 again.
